// File: rtl/matmul_apb_slave.sv
// rtl/matmul_apb_slave.sv - APB responder for the matmul accelerator: register/operand decode, result storage, start/busy tracking.
// Writes complete in the first ACCESS cycle; reads register data and complete one cycle later.
module matmul_apb_slave #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           psel_i,
  input  logic                           penable_i,
  input  logic                           pwrite_i,
  input  logic [MAX_DIM-1:0]             pstrb_i,
  input  logic [BUS_WIDTH-1:0]           pwdata_i,
  input  logic [ADDR_WIDTH-1:0]          paddr_i,
  output logic                           pready_o,
  output logic                           pslverr_o,
  output logic [BUS_WIDTH-1:0]           prdata_o,
  output logic                           busy_o,
  output logic                           start_o,
  output logic [BUS_WIDTH-1:0]           ctrl_o,
  input  logic [$clog2(MAX_DIM)-1:0]     a_raddr_i,
  output logic [BUS_WIDTH-1:0]           a_rdata_o,
  input  logic [$clog2(MAX_DIM)-1:0]     b_raddr_i,
  output logic [BUS_WIDTH-1:0]           b_rdata_o,
  input  logic                           sp_we_i,
  input  logic [2*$clog2(MAX_DIM)-1:0]   sp_waddr_i,
  input  logic [BUS_WIDTH-1:0]           sp_wdata_i,
  input  logic                           flags_we_i,
  input  logic [BUS_WIDTH-1:0]           flags_i,
  input  logic                           done_i
);

  localparam int LW  = $clog2(MAX_DIM);
  localparam int NSP = MAX_DIM * MAX_DIM;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RDWAIT} state_e;

  state_e                 state_q, state_d;
  logic [BUS_WIDTH-1:0]   ctrl_q, ctrl_d;
  logic                   busy_q, busy_d;
  logic                   start_q, start_d;
  logic [BUS_WIDTH-1:0]   prdata_q, prdata_d;
  logic                   rd_err_q, rd_err_d;
  logic [BUS_WIDTH-1:0]   a_q [MAX_DIM];
  logic [BUS_WIDTH-1:0]   b_q [MAX_DIM];
  logic [BUS_WIDTH-1:0]   sp_q [NSP];
  logic [BUS_WIDTH-1:0]   flags_q;

  logic [4:0]             offset;
  logic [LW-1:0]          line_idx;
  logic [2*LW-1:0]        elem_idx;
  logic                   is_ctrl, is_a, is_b, is_flags, is_sp, mapped;
  logic                   access_ok, wr_err, wr_fire, rd_fire, launch;
  logic [BUS_WIDTH-1:0]   rd_data;
  logic                   unused_paddr;

  function automatic logic [BUS_WIDTH-1:0] merge_lanes(input logic [BUS_WIDTH-1:0] old_v,
                                                        input logic [BUS_WIDTH-1:0] new_v,
                                                        input logic [MAX_DIM-1:0]   strb);
    logic [BUS_WIDTH-1:0] res;
    res = old_v;
    for (int k = 0; k < MAX_DIM; k++) begin
      if (strb[k]) res[k*DATA_WIDTH +: DATA_WIDTH] = new_v[k*DATA_WIDTH +: DATA_WIDTH];
    end
    return res;
  endfunction

  assign offset       = paddr_i[4:0];
  assign line_idx     = paddr_i[5 +: LW];
  assign elem_idx     = paddr_i[5 +: 2*LW];
  assign unused_paddr = ^paddr_i[ADDR_WIDTH-1:5+2*LW];

  assign is_ctrl  = (offset == 5'h00);
  assign is_a     = (offset == 5'h04);
  assign is_b     = (offset == 5'h08);
  assign is_flags = (offset == 5'h0C);
  assign is_sp    = (offset == 5'h10);
  assign mapped   = is_ctrl | is_a | is_b | is_flags | is_sp;

  // Only CONTROL/A/B are writable, and only while the core is idle.
  assign wr_err    = !(is_ctrl | is_a | is_b) | busy_q;
  assign access_ok = (state_q == ACCESS) && psel_i;
  assign wr_fire   = access_ok && pwrite_i && !wr_err;
  assign rd_fire   = access_ok && !pwrite_i;
  assign launch    = wr_fire && is_ctrl && pstrb_i[0] && pwdata_i[0];

  always_comb begin
    rd_data = '0;
    if (is_ctrl)       rd_data = ctrl_q;
    else if (is_a)     rd_data = a_q[line_idx];
    else if (is_b)     rd_data = b_q[line_idx];
    else if (is_flags) rd_data = flags_q;
    else if (is_sp)    rd_data = sp_q[elem_idx];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (psel_i && !penable_i) state_d = SETUP;
      SETUP:  if (!psel_i) state_d = IDLE;
              else if (penable_i) state_d = ACCESS;
      ACCESS: if (!psel_i || pwrite_i) state_d = IDLE;
              else state_d = RDWAIT;
      RDWAIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    busy_d   = busy_q;
    start_d  = launch;
    prdata_d = prdata_q;
    rd_err_d = rd_err_q;
    if (wr_fire && is_ctrl) begin
      ctrl_d    = merge_lanes(ctrl_q, pwdata_i, pstrb_i);
      ctrl_d[0] = 1'b0;
    end
    if (launch)      busy_d = 1'b1;
    else if (done_i) busy_d = 1'b0;
    if (rd_fire) begin
      prdata_d = mapped ? rd_data : '0;
      rd_err_d = !mapped;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      prdata_q <= '0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      prdata_q <= prdata_d;
      rd_err_q <= rd_err_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MAX_DIM; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
      for (int i = 0; i < NSP; i++) sp_q[i] <= '0;
      flags_q <= '0;
    end else begin
      if (wr_fire && is_a) a_q[line_idx] <= merge_lanes(a_q[line_idx], pwdata_i, pstrb_i);
      if (wr_fire && is_b) b_q[line_idx] <= merge_lanes(b_q[line_idx], pwdata_i, pstrb_i);
      if (sp_we_i)    sp_q[sp_waddr_i] <= sp_wdata_i;
      if (flags_we_i) flags_q <= flags_i;
    end
  end

  // Write responses are combinational in ACCESS; read responses come from the registered capture.
  assign pready_o  = (access_ok && pwrite_i) || (state_q == RDWAIT);
  assign pslverr_o = (access_ok && pwrite_i && wr_err) || ((state_q == RDWAIT) && rd_err_q);
  assign prdata_o  = prdata_q;
  assign busy_o    = busy_q;
  assign start_o   = start_q;
  assign ctrl_o    = ctrl_q;
  assign a_rdata_o = a_q[a_raddr_i];
  assign b_rdata_o = b_q[b_raddr_i];

endmodule
